mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
package mem_arb_pkg;

    localparam int MEMSIZE   = 'h400;
    localparam int WIDTH     = $clog2(MEMSIZE);
    localparam int NUM_PORTS = 2;
    localparam int PORT_IMEM = 0;
    localparam int PORT_DMEM = 1;

    typedef struct packed {
        logic             wen;
        logic [WIDTH-1:0] addr;
        logic [31:0]      wdata;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_IDLE = '0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle of mem_arbiter.
// slave = arbiter view; master = requesters plus the attached rwmemory.
interface mem_arbiter_if #(
    parameter int WIDTH = mem_arb_pkg::WIDTH
);
    logic [1:0]       req_valid;
    logic [1:0]       req_wen;
    logic [WIDTH-1:0] req_addr0;
    logic [WIDTH-1:0] req_addr1;
    logic [31:0]      req_wdata0;
    logic [31:0]      req_wdata1;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata0;
    logic [31:0]      resp_rdata1;
    logic             mem_en;
    logic             mem_wen;
    logic [WIDTH-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata0, resp_rdata1,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wen, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata0, resp_rdata1,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: a lone requester wins, on a conflict the
// port that did not win last time wins. Purely combinational.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of latches.
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port rwmemory between instruction fetch (port 0) and
// load/store (port 1). Optional counters enabled by `define MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEMSIZE = mem_arb_pkg::MEMSIZE
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0] stat_grants0,
    output logic [31:0] stat_grants1,
    output logic [31:0] stat_conflicts,
`endif
    mem_arbiter_if.slave bus
);

    localparam int ADDR_W = $clog2(MEMSIZE);

    logic [1:0]  grant;
    logic [1:0]  ready;
    mem_req_t    req [NUM_PORTS];
    mem_req_t    sel;

    logic        last_grant_q, last_grant_d;
    logic [1:0]  resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata0_q, resp_rdata0_d;
    logic [31:0] resp_rdata1_q, resp_rdata1_d;

    rr_arbiter2 u_rr (
        .valid      (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Grant and memory drive; nothing is granted while reset is held.
    always_comb begin
        req[PORT_IMEM] = '{wen: bus.req_wen[PORT_IMEM], addr: bus.req_addr0, wdata: bus.req_wdata0};
        req[PORT_DMEM] = '{wen: bus.req_wen[PORT_DMEM], addr: bus.req_addr1, wdata: bus.req_wdata1};
        ready = reset ? 2'b00 : grant;
        sel   = MEM_REQ_IDLE;
        if (ready[PORT_IMEM])      sel = req[PORT_IMEM];
        else if (ready[PORT_DMEM]) sel = req[PORT_DMEM];

        bus.req_ready = ready;
        bus.mem_en    = |ready;
        bus.mem_wen   = sel.wen;
        bus.mem_addr  = ADDR_W'(sel.addr);
        bus.mem_wdata = sel.wdata;
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        resp_valid_d  = ready;
        resp_rdata0_d = resp_rdata0_q;
        resp_rdata1_d = resp_rdata1_q;
        if (|ready) last_grant_d = ready[PORT_DMEM];
        // Writes complete with zero data; reads capture the combinational memory output.
        if (ready[PORT_IMEM]) resp_rdata0_d = sel.wen ? 32'h0 : bus.mem_rdata;
        if (ready[PORT_DMEM]) resp_rdata1_d = sel.wen ? 32'h0 : bus.mem_rdata;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q  <= 1'b1;
            resp_valid_q  <= 2'b00;
            resp_rdata0_q <= 32'h0;
            resp_rdata1_q <= 32'h0;
        end else begin
            last_grant_q  <= last_grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata0_q <= resp_rdata0_d;
            resp_rdata1_q <= resp_rdata1_d;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata0 = resp_rdata0_q;
    assign bus.resp_rdata1 = resp_rdata1_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_grants0_q, stat_grants0_d;
    logic [31:0] stat_grants1_q, stat_grants1_d;
    logic [31:0] stat_conflicts_q, stat_conflicts_d;

    always_comb begin
        stat_grants0_d   = stat_grants0_q + {31'h0, ready[PORT_IMEM]};
        stat_grants1_d   = stat_grants1_q + {31'h0, ready[PORT_DMEM]};
        stat_conflicts_d = stat_conflicts_q + {31'h0, &bus.req_valid};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants0_q   <= 32'h0;
            stat_grants1_q   <= 32'h0;
            stat_conflicts_q <= 32'h0;
        end else begin
            stat_grants0_q   <= stat_grants0_d;
            stat_grants1_q   <= stat_grants1_d;
            stat_conflicts_q <= stat_conflicts_d;
        end
    end

    assign stat_grants0   = stat_grants0_q;
    assign stat_grants1   = stat_grants1_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural rwmemory.
// Unwritten memory words read as 32'hA000_0000 | word_index.
module tb_mem_arbiter;

    localparam int WIDTH = mem_arb_pkg::WIDTH;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_grants0, stat_grants1, stat_conflicts;
`endif

    mem_arbiter #(.MEMSIZE('h400)) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef MEM_ARB_STATS_EN
        .stat_grants0   (stat_grants0),
        .stat_grants1   (stat_grants1),
        .stat_conflicts (stat_conflicts),
`endif
        .bus            (bus)
    );

    logic [31:0] mem [256];
    logic        written [256] = '{default: 1'b0};
    logic [7:0]  widx;

    assign widx          = bus.mem_addr[WIDTH-1:2];
    assign bus.mem_rdata = written[widx] ? mem[widx] : (32'hA000_0000 | {24'h0, widx});

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_wen) begin
            mem[widx]     <= bus.mem_wdata;
            written[widx] <= 1'b1;
        end
    end

    typedef struct {
        logic [1:0]       valid;
        logic [1:0]       wen;
        logic [WIDTH-1:0] a0, a1;
        logic [31:0]      d0, d1;
        logic [1:0]       ready;
        logic             en, mwen;
        logic [WIDTH-1:0] maddr;
        logic [31:0]      mwdata;
        logic [1:0]       rv;
        logic [31:0]      r0, r1;
    } vec_t;

    function automatic vec_t mk(
        logic [1:0] valid, logic [1:0] wen, logic [WIDTH-1:0] a0, logic [WIDTH-1:0] a1,
        logic [31:0] d0, logic [31:0] d1,
        logic [1:0] ready, logic en, logic mwen, logic [WIDTH-1:0] maddr, logic [31:0] mwdata,
        logic [1:0] rv, logic [31:0] r0, logic [31:0] r1);
        vec_t v;
        v.valid = valid; v.wen = wen; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.ready = ready; v.en = en; v.mwen = mwen; v.maddr = maddr; v.mwdata = mwdata;
        v.rv = rv; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] valid, input logic [1:0] wen,
                         input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        bus.req_valid  = valid;
        bus.req_wen    = wen;
        bus.req_addr0  = a0;
        bus.req_addr1  = a1;
        bus.req_wdata0 = d0;
        bus.req_wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [17];

    initial begin
        // Idle vectors drive junk on addr/data to prove mem_* is zeroed without a grant.
        vecs[0]  = mk(2'b00, 2'b00, 'h3FC, 'h3F8, 32'hFFFFFFFF, 32'hEEEEEEEE, 2'b00, 0, 0, 'h000, 32'h0,        2'b00, 32'h0,        32'h0);
        vecs[1]  = mk(2'b11, 2'b00, 'h000, 'h004, 32'h11111111, 32'h22222222, 2'b01, 1, 0, 'h000, 32'h11111111, 2'b00, 32'h0,        32'h0);
        vecs[2]  = mk(2'b10, 2'b00, 'h000, 'h004, 32'h11111111, 32'h22222222, 2'b10, 1, 0, 'h004, 32'h22222222, 2'b01, 32'hA0000000, 32'h0);
        vecs[3]  = mk(2'b01, 2'b01, 'h010, 'h000, 32'hDEADBEEF, 32'h0,        2'b01, 1, 1, 'h010, 32'hDEADBEEF, 2'b10, 32'hA0000000, 32'hA0000001);
        vecs[4]  = mk(2'b01, 2'b00, 'h010, 'h000, 32'h55555555, 32'h0,        2'b01, 1, 0, 'h010, 32'h55555555, 2'b01, 32'h0,        32'hA0000001);
        vecs[5]  = mk(2'b00, 2'b00, 'h3FC, 'h3F8, 32'hFFFFFFFF, 32'hEEEEEEEE, 2'b00, 0, 0, 'h000, 32'h0,        2'b01, 32'hDEADBEEF, 32'hA0000001);
        vecs[6]  = mk(2'b10, 2'b00, 'h000, 'h00B, 32'h0,        32'h0,        2'b10, 1, 0, 'h00B, 32'h0,        2'b00, 32'hDEADBEEF, 32'hA0000001);
        vecs[7]  = mk(2'b11, 2'b00, 'h00C, 'h014, 32'h0,        32'h0,        2'b01, 1, 0, 'h00C, 32'h0,        2'b10, 32'hDEADBEEF, 32'hA0000002);
        vecs[8]  = mk(2'b11, 2'b00, 'h00C, 'h014, 32'h0,        32'h0,        2'b10, 1, 0, 'h014, 32'h0,        2'b01, 32'hA0000003, 32'hA0000002);
        vecs[9]  = mk(2'b11, 2'b00, 'h00C, 'h014, 32'h0,        32'h0,        2'b01, 1, 0, 'h00C, 32'h0,        2'b10, 32'hA0000003, 32'hA0000005);
        vecs[10] = mk(2'b11, 2'b00, 'h00C, 'h014, 32'h0,        32'h0,        2'b10, 1, 0, 'h014, 32'h0,        2'b01, 32'hA0000003, 32'hA0000005);
        vecs[11] = mk(2'b11, 2'b00, 'h00C, 'h014, 32'h0,        32'h0,        2'b01, 1, 0, 'h00C, 32'h0,        2'b10, 32'hA0000003, 32'hA0000005);
        vecs[12] = mk(2'b11, 2'b00, 'h00C, 'h014, 32'h0,        32'h0,        2'b10, 1, 0, 'h014, 32'h0,        2'b01, 32'hA0000003, 32'hA0000005);
        vecs[13] = mk(2'b11, 2'b10, 'h020, 'h020, 32'h0,        32'h12345678, 2'b01, 1, 0, 'h020, 32'h0,        2'b10, 32'hA0000003, 32'hA0000005);
        vecs[14] = mk(2'b10, 2'b10, 'h020, 'h020, 32'h0,        32'h12345678, 2'b10, 1, 1, 'h020, 32'h12345678, 2'b01, 32'hA0000008, 32'hA0000005);
        vecs[15] = mk(2'b01, 2'b00, 'h020, 'h000, 32'h0,        32'h0,        2'b01, 1, 0, 'h020, 32'h0,        2'b10, 32'hA0000008, 32'h0);
        vecs[16] = mk(2'b00, 2'b00, 'h3FC, 'h3F8, 32'hFFFFFFFF, 32'hEEEEEEEE, 2'b00, 0, 0, 'h000, 32'h0,        2'b01, 32'h12345678, 32'h0);

        reset = 1'b1;
        drive(2'b00, 2'b00, '0, '0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].wen, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            check($sformatf("v%0d.req_ready", i),   {30'h0, bus.req_ready},  {30'h0, vecs[i].ready});
            check($sformatf("v%0d.mem_en", i),      {31'h0, bus.mem_en},     {31'h0, vecs[i].en});
            check($sformatf("v%0d.mem_wen", i),     {31'h0, bus.mem_wen},    {31'h0, vecs[i].mwen});
            check($sformatf("v%0d.mem_addr", i),    32'(bus.mem_addr),       32'(vecs[i].maddr));
            check($sformatf("v%0d.mem_wdata", i),   bus.mem_wdata,           vecs[i].mwdata);
            check($sformatf("v%0d.resp_valid", i),  {30'h0, bus.resp_valid}, {30'h0, vecs[i].rv});
            check($sformatf("v%0d.resp_rdata0", i), bus.resp_rdata0,         vecs[i].r0);
            check($sformatf("v%0d.resp_rdata1", i), bus.resp_rdata1,         vecs[i].r1);
            next_cycle();
        end

        // Reset lands in the middle of a granted read while last_grant is 0.
        drive(2'b01, 2'b00, 'h010, 'h000, 32'h0, 32'h0);
        @(negedge clk);
        check("rst.pre_ready", {30'h0, bus.req_ready}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst.ready_in_reset",  {30'h0, bus.req_ready}, 32'h0);
        check("rst.mem_en_in_reset", {31'h0, bus.mem_en},    32'h0);
        check("rst.rdata0_async",    bus.resp_rdata0,        32'h0);
        next_cycle();
        reset = 1'b0;
        drive(2'b00, 2'b00, '0, '0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst.resp_valid", {30'h0, bus.resp_valid}, 32'h0);
        check("rst.rdata0",     bus.resp_rdata0,         32'h0);
        check("rst.rdata1",     bus.resp_rdata1,         32'h0);
        next_cycle();
        drive(2'b11, 2'b00, 'h000, 'h004, 32'h0, 32'h0);
        @(negedge clk);
        check("rst.last_grant_is_1", {30'h0, bus.req_ready}, 32'h1);
        next_cycle();
        drive(2'b00, 2'b00, '0, '0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst.post_resp_valid", {30'h0, bus.resp_valid}, 32'h1);
        check("rst.post_rdata0",     bus.resp_rdata0,         32'hA0000000);

`ifdef MEM_ARB_STATS_EN
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("stat.grants0_rst",   stat_grants0,   32'h0);
        check("stat.grants1_rst",   stat_grants1,   32'h0);
        check("stat.conflicts_rst", stat_conflicts, 32'h0);
        next_cycle();
        drive(2'b11, 2'b00, 'h000, 'h004, 32'h0, 32'h0);
        repeat (4) next_cycle();
        drive(2'b01, 2'b00, 'h008, 'h000, 32'h0, 32'h0);
        repeat (2) next_cycle();
        drive(2'b00, 2'b00, '0, '0, 32'h0, 32'h0);
        @(negedge clk);
        check("stat.conflicts", stat_conflicts, 32'd4);
        check("stat.grants0",   stat_grants0,   32'd4);
        check("stat.grants1",   stat_grants1,   32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
